// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one imem request at a time, and buffers words for decode.
// Handles redirects and HALT. Define FETCH_NOP_SQUASH_EN to keep NOP words out of the buffer.
module inst_fetch_unit #(
   parameter int              IW       = 16,
   parameter int              AW       = 16,
   parameter logic [AW-1:0]   RESET_PC = '0,
   parameter int              DEPTH    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_rvalid,
   input  logic [IW-1:0] imem_rdata,
   output logic          inst_valid,
   input  logic          inst_ready,
   output logic [IW-1:0] inst_data,
   output logic [3:0]    inst_opcode,
   output logic [AW-1:0] inst_pc,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_pc,
   input  logic          resume,
   output logic          halted
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_DROP   = 2'd2;
   localparam logic [1:0] ST_HALTED = 2'd3;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_HALT = 4'b0001;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [IW-1:0] word;
   } entry_t;

   logic [1:0]       state, state_d;
   logic [AW-1:0]    pc, pc_d;
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count;
   logic             push, pop, outstanding;
   logic [3:0]       rdata_op;
   logic             squash;
   entry_t           buf_mem [DEPTH];
   entry_t           head;

   assign rdata_op    = imem_rdata[IW-1:IW-4];
   assign outstanding = (state == ST_WAIT) || (state == ST_DROP);

`ifdef FETCH_NOP_SQUASH_EN
   assign squash = (rdata_op == OP_NOP);
`else
   assign squash = 1'b0;
`endif

   always_comb begin
      // NOTE: combinational blocks use blocking '=' with a default for every output first, so no latch is inferred.
      state_d = state;
      pc_d    = pc;
      push    = 1'b0;
      case (state)
         ST_RUN: begin
            if (count < FULL) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               pc_d    = pc + AW'(1);
               push    = !squash;
               state_d = (rdata_op == OP_HALT) ? ST_HALTED : ST_RUN;
            end
         end
         ST_DROP: begin
            if (imem_rvalid) state_d = ST_RUN;
         end
         ST_HALTED: begin
            if (resume) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
      // A redirect overrides everything; a response already in flight must be swallowed in DROP.
      if (redirect_valid) begin
         pc_d    = redirect_pc;
         push    = 1'b0;
         state_d = (outstanding && !imem_rvalid) ? ST_DROP : ST_RUN;
      end
   end

   assign pop = inst_valid && inst_ready && !redirect_valid;

   // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
         pc    <= RESET_PC;
      end else begin
         state <= state_d;
         pc    <= pc_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   // NOTE: buffer storage is not reset; validity comes from count, and the outputs are zeroed while empty.
   always_ff @(posedge clk) begin
      if (push) buf_mem[wr_ptr] <= '{pc: pc, word: imem_rdata};
   end

   assign head        = buf_mem[rd_ptr];
   assign inst_valid  = (count != '0);
   assign inst_data   = inst_valid ? head.word : '0;
   assign inst_pc     = inst_valid ? head.pc : '0;
   assign inst_opcode = inst_data[IW-1:IW-4];

   assign imem_req  = (state == ST_WAIT);
   assign imem_addr = pc;
   assign halted    = (state == ST_HALTED);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: imem model with programmable latency, expected-word queue checked at each pop.
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [15:0] imem_rdata = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [15:0] inst_data;
   logic [3:0]  inst_opcode;
   logic [15:0] inst_pc;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic        resume = 1'b0;
   logic        halted;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] word;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_pass = 0;
   logic [15:0] imem [65536];
   int          lat = 1;
   int          busy = 0;
   int          cnt = 0;
   int          n_issued = 0;
   logic [15:0] lat_addr = '0;

   inst_fetch_unit #(.IW(16), .AW(16), .RESET_PC(16'h0000), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_data(inst_data), .inst_opcode(inst_opcode), .inst_pc(inst_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .resume(resume), .halted(halted)
   );

   always #5 clk = ~clk;

   // imem model: a request first seen in cycle k is answered with a one-cycle rvalid in cycle k+lat.
   always @(posedge clk) begin
      #1;
      imem_rvalid = 1'b0;
      if (!rst_n) begin
         busy = 0;
      end else if (busy != 0) begin
         cnt = cnt - 1;
         if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = imem[lat_addr];
            busy        = 0;
         end
      end else if (imem_req) begin
         busy     = 1;
         cnt      = lat;
         lat_addr = imem_addr;
         n_issued = n_issued + 1;
      end
   end

   // Scoreboard: every accepted head word must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_extra: got pc=%h data=%h, want no delivery", inst_pc, inst_data);
         end else begin
            e = exp_q.pop_front();
            if (inst_pc !== e.pc || inst_data !== e.word || inst_opcode !== e.word[15:12])
               $display("FAIL scoreboard: got pc=%h data=%h op=%h, want pc=%h data=%h op=%h",
                        inst_pc, inst_data, inst_opcode, e.pc, e.word, e.word[15:12]);
            else
               n_pass++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_mem();
      for (int i = 0; i < 65536; i++) imem[i] = 16'h5000 | 16'(i & 16'h0fff);
   endtask

   task automatic expect_word(input logic [15:0] a);
      exp_t e;
      e.pc   = a;
      e.word = imem[a];
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      inst_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      resume = 1'b0;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_level(input logic want, input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (imem_req === want) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_halted(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (halted === 1'b1 && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      fill_mem();
      lat = 1;
      inst_ready = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) tick();
      n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0000 || imem_req !== 1'b0)
         $display("FAIL prefill: got valid=%b pc=%h req=%b, want 1 0000 0", inst_valid, inst_pc, imem_req); else n_pass++;
      #3 rst_n = 1'b0;
      #1;
      n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else n_pass++;
      n_checks++; if (imem_addr !== 16'h0000) $display("FAIL reset_addr: got %h want 0000", imem_addr); else n_pass++;
      n_checks++; if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", inst_valid); else n_pass++;
      n_checks++; if (inst_data !== 16'h0000) $display("FAIL reset_data: got %h want 0000", inst_data); else n_pass++;
      n_checks++; if (inst_opcode !== 4'h0) $display("FAIL reset_opcode: got %h want 0", inst_opcode); else n_pass++;
      n_checks++; if (inst_pc !== 16'h0000) $display("FAIL reset_pc: got %h want 0000", inst_pc); else n_pass++;
      n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else n_pass++;
   endtask

   task automatic test_halt_resume();
      bit ok;
      int reqs;
      fill_mem();
      imem[0] = 16'h3123; imem[1] = 16'h2456; imem[2] = 16'h1000;
      imem[3] = 16'h2777; imem[4] = 16'h1000;
      lat = 1;
      do_reset();
      for (int a = 0; a < 3; a++) expect_word(16'(a));
      inst_ready = 1'b1;
      wait_halted(60, ok);
      n_checks++; if (!ok) $display("FAIL halt_drain: got halted=%b pending=%0d, want 1 0", halted, exp_q.size()); else n_pass++;
      reqs = 0;
      repeat (10) begin
         tick();
         if (imem_req) reqs++;
      end
      n_checks++; if (reqs != 0 || halted !== 1'b1)
         $display("FAIL halt_idle: got req_cycles=%0d halted=%b, want 0 1", reqs, halted); else n_pass++;
      expect_word(16'h0003);
      expect_word(16'h0004);
      resume = 1'b1;
      tick();
      resume = 1'b0;
      n_checks++; if (halted !== 1'b0) $display("FAIL resume_unhalt: got %b want 0", halted); else n_pass++;
      wait_level(1'b1, 10, ok);
      n_checks++; if (!ok || imem_addr !== 16'h0003)
         $display("FAIL resume_addr: got req=%b addr=%h, want 1 0003", imem_req, imem_addr); else n_pass++;
      wait_halted(60, ok);
      n_checks++; if (!ok) $display("FAIL resume_drain: got halted=%b pending=%0d, want 1 0", halted, exp_q.size()); else n_pass++;
   endtask

   task automatic test_backpressure();
      bit ok;
      int base;
      fill_mem();
      imem[3] = 16'h1000;
      lat = 1;
      do_reset();
      base = n_issued;
      for (int a = 0; a < 4; a++) expect_word(16'(a));
      inst_ready = 1'b0;
      repeat (20) tick();
      n_checks++; if (n_issued - base != 2 || imem_req !== 1'b0)
         $display("FAIL bp_fill: got issued=%0d req=%b, want 2 0", n_issued - base, imem_req); else n_pass++;
      n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0000)
         $display("FAIL bp_head: got valid=%b pc=%h, want 1 0000", inst_valid, inst_pc); else n_pass++;
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      wait_level(1'b1, 5, ok);
      n_checks++; if (!ok || imem_addr !== 16'h0002)
         $display("FAIL bp_refill_addr: got req=%b addr=%h, want 1 0002", imem_req, imem_addr); else n_pass++;
      repeat (10) tick();
      n_checks++; if (n_issued - base != 3 || inst_pc !== 16'h0001)
         $display("FAIL bp_refill: got issued=%0d head=%h, want 3 0001", n_issued - base, inst_pc); else n_pass++;
      inst_ready = 1'b1;
      wait_halted(60, ok);
      n_checks++; if (!ok) $display("FAIL bp_drain: got halted=%b pending=%0d, want 1 0", halted, exp_q.size()); else n_pass++;
   endtask

   task automatic test_redirect_wait();
      bit ok;
      fill_mem();
      imem[5] = 16'h7555; imem[16'h40] = 16'h2abc; imem[16'h41] = 16'h1000;
      lat = 3;
      do_reset();
      for (int a = 0; a < 5; a++) expect_word(16'(a));
      expect_word(16'h0040);
      expect_word(16'h0041);
      inst_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (imem_req && imem_addr == 16'h0005) begin
            ok = 1'b1;
            break;
         end
      end
      n_checks++; if (!ok) $display("FAIL rw_reach: got addr=%h, want 0005 requested", imem_addr); else n_pass++;
      redirect_valid = 1'b1;
      redirect_pc = 16'h0040;
      tick();
      redirect_valid = 1'b0;
      n_checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0 || exp_q.size() != 2)
         $display("FAIL rw_flush: got valid=%b req=%b pending=%0d, want 0 0 2", inst_valid, imem_req, exp_q.size()); else n_pass++;
      wait_level(1'b1, 20, ok);
      n_checks++; if (!ok || imem_addr !== 16'h0040)
         $display("FAIL rw_next_addr: got req=%b addr=%h, want 1 0040", imem_req, imem_addr); else n_pass++;
      wait_halted(60, ok);
      n_checks++; if (!ok) $display("FAIL rw_drain: got halted=%b pending=%0d, want 1 0", halted, exp_q.size()); else n_pass++;
   endtask

   task automatic test_redirect_rvalid();
      bit ok;
      fill_mem();
      imem[16'h10] = 16'h2010; imem[16'h11] = 16'h1000;
      lat = 2;
      do_reset();
      expect_word(16'h0010);
      expect_word(16'h0011);
      inst_ready = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (inst_valid) begin
            ok = 1'b1;
            break;
         end
      end
      n_checks++; if (!ok) $display("FAIL rr_prefill: got valid=%b want 1", inst_valid); else n_pass++;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #2;
         if (imem_rvalid) begin
            ok = 1'b1;
            break;
         end
      end
      n_checks++; if (!ok) $display("FAIL rr_rvalid: got rvalid=%b want 1", imem_rvalid); else n_pass++;
      inst_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 16'h0010;
      tick();
      redirect_valid = 1'b0;
      n_checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0)
         $display("FAIL rr_flush: got valid=%b req=%b, want 0 0", inst_valid, imem_req); else n_pass++;
      wait_level(1'b1, 10, ok);
      n_checks++; if (!ok || imem_addr !== 16'h0010)
         $display("FAIL rr_next_addr: got req=%b addr=%h, want 1 0010", imem_req, imem_addr); else n_pass++;
      wait_halted(60, ok);
      n_checks++; if (!ok) $display("FAIL rr_drain: got halted=%b pending=%0d, want 1 0", halted, exp_q.size()); else n_pass++;
   endtask

   task automatic test_redirect_drop();
      bit ok;
      fill_mem();
      imem[16'h30] = 16'h2030; imem[16'h31] = 16'h1000;
      lat = 4;
      do_reset();
      expect_word(16'h0030);
      expect_word(16'h0031);
      inst_ready = 1'b1;
      wait_level(1'b1, 10, ok);
      n_checks++; if (!ok || imem_addr !== 16'h0000)
         $display("FAIL rd_first: got req=%b addr=%h, want 1 0000", imem_req, imem_addr); else n_pass++;
      redirect_valid = 1'b1;
      redirect_pc = 16'h0020;
      tick();
      redirect_pc = 16'h0030;
      tick();
      redirect_valid = 1'b0;
      n_checks++; if (imem_req !== 1'b0) $display("FAIL rd_drop_req: got %b want 0", imem_req); else n_pass++;
      wait_level(1'b1, 20, ok);
      n_checks++; if (!ok || imem_addr !== 16'h0030)
         $display("FAIL rd_next_addr: got req=%b addr=%h, want 1 0030", imem_req, imem_addr); else n_pass++;
      wait_halted(60, ok);
      n_checks++; if (!ok) $display("FAIL rd_drain: got halted=%b pending=%0d, want 1 0", halted, exp_q.size()); else n_pass++;
   endtask

   task automatic test_wrap();
      bit ok;
      fill_mem();
      imem[0] = 16'h1000; imem[16'hFFFF] = 16'h2222;
      lat = 1;
      do_reset();
      expect_word(16'h0000);
      inst_ready = 1'b1;
      wait_halted(40, ok);
      n_checks++; if (!ok) $display("FAIL wrap_halt0: got halted=%b pending=%0d, want 1 0", halted, exp_q.size()); else n_pass++;
      expect_word(16'hFFFF);
      expect_word(16'h0000);
      redirect_valid = 1'b1;
      redirect_pc = 16'hFFFF;
      tick();
      redirect_valid = 1'b0;
      n_checks++; if (halted !== 1'b0) $display("FAIL wrap_unhalt: got %b want 0", halted); else n_pass++;
      wait_level(1'b1, 10, ok);
      n_checks++; if (!ok || imem_addr !== 16'hFFFF)
         $display("FAIL wrap_top_addr: got req=%b addr=%h, want 1 ffff", imem_req, imem_addr); else n_pass++;
      wait_level(1'b0, 10, ok);
      wait_level(1'b1, 10, ok);
      n_checks++; if (!ok || imem_addr !== 16'h0000)
         $display("FAIL wrap_addr: got req=%b addr=%h, want 1 0000", imem_req, imem_addr); else n_pass++;
      wait_halted(40, ok);
      n_checks++; if (!ok) $display("FAIL wrap_drain: got halted=%b pending=%0d, want 1 0", halted, exp_q.size()); else n_pass++;
   endtask

   task automatic test_nop();
      bit ok;
      fill_mem();
      imem[0] = 16'h0000; imem[1] = 16'h0000; imem[2] = 16'h3111; imem[3] = 16'h1000;
      lat = 1;
      do_reset();
`ifdef FETCH_NOP_SQUASH_EN
      expect_word(16'h0002);
      expect_word(16'h0003);
`else
      for (int a = 0; a < 4; a++) expect_word(16'(a));
`endif
      inst_ready = 1'b1;
      wait_halted(60, ok);
      n_checks++; if (!ok) $display("FAIL nop_drain: got halted=%b pending=%0d, want 1 0", halted, exp_q.size()); else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_halt_resume();
      test_backpressure();
      test_redirect_wait();
      test_redirect_rvalid();
      test_redirect_drop();
      test_wrap();
      test_nop();
      repeat (2) tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
